// File: rtl/retire_rat.sv
// Retirement register alias table and free-list push side.
// Records the committed arch->phys mapping of each retiring instruction and
// hands the previously committed physical register back to the free list.
// A single pending-push register sits between retirement and the free list;
// while that push is blocked by a full free list, retirement stalls.
module retire_rat #(
    parameter int NUM_ARCH_REGISTERS = 32,
    parameter int ARCH_REG_WIDTH     = 5,
    parameter int PHYS_REG_WIDTH     = 6
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          commit_valid_i,
    input  logic [ARCH_REG_WIDTH-1:0]                     commit_rd_i,
    input  logic [PHYS_REG_WIDTH-1:0]                     commit_pd_i,
    input  logic                                          commit_regf_we_i,
    output logic                                          commit_ready_o,
    output logic                                          fl_wen_o,
    output logic [PHYS_REG_WIDTH-1:0]                     fl_wdata_o,
    input  logic                                          fl_full_i,
    output logic [NUM_ARCH_REGISTERS-1:0][PHYS_REG_WIDTH-1:0] rrat_map_o,
    output logic [31:0]                                   retire_count_o
);

    logic [NUM_ARCH_REGISTERS-1:0][PHYS_REG_WIDTH-1:0] map_q, map_d;
    logic                                              pend_valid_q, pend_valid_d;
    logic [PHYS_REG_WIDTH-1:0]                         pend_data_q, pend_data_d;
    logic [31:0]                                       retire_count_q, retire_count_d;

    logic fire;
    logic map_ret;
    logic push_taken;

    // Ready only depends on whether the pending push can drain this cycle.
    assign commit_ready_o = !pend_valid_q || !fl_full_i;

    assign fl_wen_o       = pend_valid_q;
    assign fl_wdata_o     = pend_data_q;
    assign rrat_map_o     = map_q;
    assign retire_count_o = retire_count_q;

    // Next-state: a mapping retirement overrides a push taken at the same edge,
    // since the old entry leaves and the new one replaces it in one step.
    always_comb begin
        fire           = commit_valid_i && commit_ready_o;
        map_ret        = fire && commit_regf_we_i && (commit_rd_i != '0);
        push_taken     = pend_valid_q && !fl_full_i;

        map_d          = map_q;
        pend_valid_d   = pend_valid_q;
        pend_data_d    = pend_data_q;
        retire_count_d = retire_count_q + 32'(fire);

        if (map_ret) begin
            // Read-before-write: map_q holds the previous committed mapping.
            pend_data_d          = map_q[commit_rd_i];
            pend_valid_d         = 1'b1;
            map_d[commit_rd_i]   = commit_pd_i;
        end else if (push_taken) begin
            pend_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset; map resets to identity.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ARCH_REGISTERS; i++) begin
                map_q[i] <= PHYS_REG_WIDTH'(i);
            end
            pend_valid_q   <= 1'b0;
            pend_data_q    <= '0;
            retire_count_q <= '0;
        end else begin
            map_q          <= map_d;
            pend_valid_q   <= pend_valid_d;
            pend_data_q    <= pend_data_d;
            retire_count_q <= retire_count_d;
        end
    end

endmodule

// File: tb/tb_retire_rat.sv
// Directed bench for retire_rat: reset, single and back-to-back retirement,
// non-mapping retirements, free-list backpressure and reset during a stall.
module tb_retire_rat;

    localparam int NA = 32;
    localparam int AW = 5;
    localparam int PW = 6;

    logic                   clk_i;
    logic                   rst_ni;
    logic                   commit_valid_i;
    logic [AW-1:0]          commit_rd_i;
    logic [PW-1:0]          commit_pd_i;
    logic                   commit_regf_we_i;
    logic                   commit_ready_o;
    logic                   fl_wen_o;
    logic [PW-1:0]          fl_wdata_o;
    logic                   fl_full_i;
    logic [NA-1:0][PW-1:0]  rrat_map_o;
    logic [31:0]            retire_count_o;

    int errors = 0;
    int checks = 0;

    logic [NA-1:0][PW-1:0]  id_map;

    retire_rat #(
        .NUM_ARCH_REGISTERS(NA),
        .ARCH_REG_WIDTH    (AW),
        .PHYS_REG_WIDTH    (PW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .commit_valid_i  (commit_valid_i),
        .commit_rd_i     (commit_rd_i),
        .commit_pd_i     (commit_pd_i),
        .commit_regf_we_i(commit_regf_we_i),
        .commit_ready_o  (commit_ready_o),
        .fl_wen_o        (fl_wen_o),
        .fl_wdata_o      (fl_wdata_o),
        .fl_full_i       (fl_full_i),
        .rrat_map_o      (rrat_map_o),
        .retire_count_o  (retire_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_identity(input string tag);
        checks++;
        assert (rrat_map_o === id_map)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, rrat_map_o, id_map);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rd, input logic [PW-1:0] pd,
                         input logic we);
        commit_valid_i   = v;
        commit_rd_i      = rd;
        commit_pd_i      = pd;
        commit_regf_we_i = we;
    endtask

    initial begin
        for (int i = 0; i < NA; i++) id_map[i] = PW'(i);

        rst_ni    = 1'b0;
        fl_full_i = 1'b0;
        drive(1'b0, '0, '0, 1'b0);

        // Reset held for two edges
        tick();
        tick();
        rst_ni = 1'b1;
        check("rst_map5", 32'(rrat_map_o[5]), 32'd5);
        check("rst_fl_wen", 32'(fl_wen_o), 32'd0);
        check("rst_fl_wdata", 32'(fl_wdata_o), 32'd0);
        check("rst_ready", 32'(commit_ready_o), 32'd1);
        check("rst_count", retire_count_o, 32'd0);
        check_identity("rst_identity");

        // Single retirement rd=3 pd=40
        drive(1'b1, 5'd3, 6'd40, 1'b1);
        #1;
        check("single_ready", 32'(commit_ready_o), 32'd1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("single_wen", 32'(fl_wen_o), 32'd1);
        check("single_wdata", 32'(fl_wdata_o), 32'd3);
        check("single_map3", 32'(rrat_map_o[3]), 32'd40);
        check("single_count", retire_count_o, 32'd1);
        tick();
        check("single_drained", 32'(fl_wen_o), 32'd0);

        // Back-to-back rd=7: pd=33 then pd=34
        drive(1'b1, 5'd7, 6'd33, 1'b1);
        tick();
        check("b2b_wdata0", 32'(fl_wdata_o), 32'd7);
        check("b2b_map7_0", 32'(rrat_map_o[7]), 32'd33);
        drive(1'b1, 5'd7, 6'd34, 1'b1);
        #1;
        check("b2b_ready", 32'(commit_ready_o), 32'd1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("b2b_wen1", 32'(fl_wen_o), 32'd1);
        check("b2b_wdata1", 32'(fl_wdata_o), 32'd33);
        check("b2b_map7_1", 32'(rrat_map_o[7]), 32'd34);
        check("b2b_count", retire_count_o, 32'd3);
        tick();
        check("b2b_drained", 32'(fl_wen_o), 32'd0);

        // rd=0 retirement, then a store (regf_we=0) to rd=5
        drive(1'b1, 5'd0, 6'd50, 1'b1);
        tick();
        check("zero_wen", 32'(fl_wen_o), 32'd0);
        drive(1'b1, 5'd5, 6'd51, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("store_wen", 32'(fl_wen_o), 32'd0);
        check("zero_map0", 32'(rrat_map_o[0]), 32'd0);
        check("store_map5", 32'(rrat_map_o[5]), 32'd5);
        check("zero_count", retire_count_o, 32'd5);

        // Set up a pending push of phys 3: map rd12->3, then rd12->45
        drive(1'b1, 5'd12, 6'd3, 1'b1);
        tick();
        drive(1'b1, 5'd12, 6'd45, 1'b1);
        tick();
        check("bp_setup_wdata", 32'(fl_wdata_o), 32'd3);

        // Backpressure: full while push of 3 pending, rd=4 pd=41 offered
        fl_full_i = 1'b1;
        drive(1'b1, 5'd4, 6'd41, 1'b1);
        #1;
        check("bp_ready0", 32'(commit_ready_o), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_ready", 32'(commit_ready_o), 32'd0);
            check("bp_wen", 32'(fl_wen_o), 32'd1);
            check("bp_wdata", 32'(fl_wdata_o), 32'd3);
            check("bp_map4", 32'(rrat_map_o[4]), 32'd4);
            check("bp_count", retire_count_o, 32'd7);
        end
        fl_full_i = 1'b0;
        #1;
        check("bp_release_ready", 32'(commit_ready_o), 32'd1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("bp_after_wen", 32'(fl_wen_o), 32'd1);
        check("bp_after_wdata", 32'(fl_wdata_o), 32'd4);
        check("bp_after_map4", 32'(rrat_map_o[4]), 32'd41);
        check("bp_after_count", retire_count_o, 32'd8);

        // Mid-stall reset: push of 4 pending and blocked
        fl_full_i = 1'b1;
        #1;
        check("stall_ready", 32'(commit_ready_o), 32'd0);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("mrst_wen", 32'(fl_wen_o), 32'd0);
        check("mrst_wdata", 32'(fl_wdata_o), 32'd0);
        check("mrst_ready", 32'(commit_ready_o), 32'd1);
        check("mrst_count", retire_count_o, 32'd0);
        check_identity("mrst_identity");
        fl_full_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
